fake_rd_multi: RTL

//  Parametrised fake Radio Detector (RD) data source for exercising rd_interface
//  and downstream memories without RD hardware. On a trigger it emits N_CH

---
 rtl/fake_rd_pkg.sv | 30 +++
 rtl/fake_rd_chan.sv | 83 ++++++++
 rtl/rd_synchronizer.sv | 18 +
 rtl/fake_rd_multi.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fake_rd_pkg.sv
// Shared types, constants and helpers for the fake Radio Detector source.
package fake_rd_pkg;

   typedef enum logic [1:0] {
      MODE_RAMP_UP = 2'd0,
      MODE_RAMP_DN = 2'd1,
      MODE_LEGACY  = 2'd2,
      MODE_LFSR    = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TDLY,
      ST_PRE,
      ST_SHIFT,
      ST_POST
   } state_e;

   localparam logic [15:0] LFSR_POLY = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   function automatic int frame_cycles(input int n_words, input int word_w);
      return n_words * (word_w + 1);
   endfunction

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return l[0] ? ((l >> 1) ^ LFSR_POLY) : (l >> 1);
   endfunction

endpackage

// File: rtl/fake_rd_chan.sv
// One serial channel: pattern generator, MSB-first shifter, parity tracker.
module fake_rd_chan
   import fake_rd_pkg::*;
#(
   parameter int WORD_W     = 12,
   parameter int PARITY_ODD = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       shift,
   input  logic       last,
   input  mode_e      mode,
   input  logic [2:0] chan,
   output logic       sout
);

   logic [WORD_W-1:0] k_q, k_d;
   logic [WORD_W-1:0] sh_q, sh_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic              par_q, par_d;
   logic [WORD_W-1:0] c_w;
   logic [15:0]       seed;

   assign c_w  = WORD_W'(chan);
   assign seed = LFSR_SEED ^ 16'(chan);

   function automatic logic [WORD_W-1:0] pattern(
      input mode_e             m,
      input logic [WORD_W-1:0] k,
      input logic [15:0]       l,
      input logic [WORD_W-1:0] c
   );
      logic [WORD_W-1:0] w;
      unique case (m)
         MODE_RAMP_UP: w = k + c;
         MODE_RAMP_DN: w = '0 - k - c;
         MODE_LEGACY:  w = c[0] ? ('0 - k) : k;
         default:      w = l[WORD_W-1:0];
      endcase
      return w;
   endfunction

   always_comb begin
      k_d    = k_q;
      sh_d   = sh_q;
      lfsr_d = lfsr_q;
      par_d  = par_q;
      if (load) begin
         k_d    = '0;
         lfsr_d = seed;
         sh_d   = pattern(mode, '0, seed, c_w);
         par_d  = 1'b0;
      end else if (shift) begin
         sh_d  = {sh_q[WORD_W-2:0], 1'b0};
         par_d = par_q ^ sh_q[WORD_W-1];
      end else if (last) begin
         // Next word is prepared during the parity bit so it follows gaplessly
         k_d    = k_q + WORD_W'(1);
         lfsr_d = lfsr_step(lfsr_q);
         sh_d   = pattern(mode, k_d, lfsr_d, c_w);
         par_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k_q    <= '0;
         sh_q   <= '0;
         lfsr_q <= '0;
         par_q  <= 1'b0;
      end else begin
         k_q    <= k_d;
         sh_q   <= sh_d;
         lfsr_q <= lfsr_d;
         par_q  <= par_d;
      end
   end

   assign sout = last  ? (par_q ^ (PARITY_ODD != 0)) :
                 shift ? sh_q[WORD_W-1] : 1'b1;

endmodule

// File: rtl/rd_synchronizer.sv
// Two-flop synchronizer for asynchronous level inputs.
module rd_synchronizer (
   input  logic clk,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      meta_q <= d;
      sync_q <= meta_q;
   end

   assign q = sync_q;

endmodule

// File: rtl/fake_rd_multi.sv
// Fake RD front end: triggered multi-channel serial burst with gated clock.
module fake_rd_multi
   import fake_rd_pkg::*;
#(
   parameter int N_CH       = 2,
   parameter int WORD_W     = 12,
   parameter int N_WORDS    = 2048,
   parameter int TRIG_DLY   = 20,
   parameter int PRE_CLKS   = 3,
   parameter int POST_CLKS  = 12,
   parameter int PARITY_ODD = 1
) (
   input  logic            LOCAL_CLK,
   input  logic            RESET,
   input  logic            ENABLE,
   input  logic            TRIGGER,
   input  logic [1:0]      MODE,
   output logic            XFR_CLK,
   output logic [N_CH-1:0] SERIAL_OUT,
   output logic            BUSY,
   output logic            DONE,
   output logic [15:0]     XFR_COUNT
);

   localparam int FRAME = frame_cycles(N_WORDS, WORD_W);
   localparam int BW    = $clog2(WORD_W + 1);

   logic          en_s, trig_s, rise;
   logic          trig_prev_q, trig_prev_d;
   state_e        state_q, state_d;
   logic [31:0]   cnt_q, cnt_d;
   logic [BW-1:0] bit_q, bit_d;
   mode_e         mode_q, mode_d;
   logic          win_q, win_d;
   logic          done_q, done_d;
   logic [15:0]   xfr_q, xfr_d;
   logic          load, shift, last;

   rd_synchronizer u_sync_en (
      .clk (LOCAL_CLK),
      .d   (ENABLE),
      .q   (en_s)
   );

   rd_synchronizer u_sync_trig (
      .clk (LOCAL_CLK),
      .d   (TRIGGER),
      .q   (trig_s)
   );

   assign load  = (state_q == ST_PRE);
   assign shift = (state_q == ST_SHIFT) && (bit_q != BW'(WORD_W));
   assign last  = (state_q == ST_SHIFT) && (bit_q == BW'(WORD_W));

   always_comb begin
      trig_prev_d = trig_s;
      rise        = trig_s & ~trig_prev_q;
      state_d     = state_q;
      cnt_d       = cnt_q + 32'd1;
      bit_d       = bit_q;
      mode_d      = mode_q;
      done_d      = 1'b0;
      xfr_d       = xfr_q;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (rise) begin
               state_d = ST_TDLY;
               mode_d  = mode_e'(MODE);
            end
         end
         ST_TDLY: begin
            if (cnt_q == 32'(TRIG_DLY - 1)) begin
               state_d = ST_PRE;
               cnt_d   = '0;
            end
         end
         ST_PRE: begin
            if (cnt_q == 32'(PRE_CLKS - 1)) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         ST_SHIFT: begin
            bit_d = last ? '0 : bit_q + BW'(1);
            if (cnt_q == 32'(FRAME - 1)) begin
               state_d = ST_POST;
               cnt_d   = '0;
            end
         end
         ST_POST: begin
            if (cnt_q == 32'(POST_CLKS - 1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               xfr_d   = xfr_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Disable wins over everything; an aborted transfer is not counted
      if (!en_s) begin
         state_d = ST_IDLE;
         done_d  = 1'b0;
         xfr_d   = xfr_q;
      end
      win_d = (state_d == ST_PRE) || (state_d == ST_SHIFT) ||
              (state_d == ST_POST);
   end

   always_ff @(posedge LOCAL_CLK) begin
      trig_prev_q <= trig_prev_d;
      if (RESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         mode_q  <= MODE_RAMP_UP;
         win_q   <= 1'b0;
         done_q  <= 1'b0;
         xfr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         mode_q  <= mode_d;
         win_q   <= win_d;
         done_q  <= done_d;
         xfr_q   <= xfr_d;
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      fake_rd_chan #(
         .WORD_W     (WORD_W),
         .PARITY_ODD (PARITY_ODD)
      ) u_chan (
         .clk   (LOCAL_CLK),
         .rst   (RESET),
         .load  (load),
         .shift (shift),
         .last  (last),
         .mode  (mode_q),
         .chan  (3'(c)),
         .sout  (SERIAL_OUT[c])
      );
   end

   assign XFR_CLK   = win_q ? ~LOCAL_CLK : 1'b1;
   assign BUSY      = (state_q != ST_IDLE) | done_q;
   assign DONE      = done_q;
   assign XFR_COUNT = xfr_q;

endmodule
